cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready flow control. WIDTH is split into PIPE equal slices. Each slice is resolved by a single-cycle lookahead unit, and its carry is registered into the next slice, so throughput is one operation per clock at any width. It replaces fixed-width, purely combinational adders wherever the datapath must close timing at wide WIDTH, and it adds carry-in, subtract mode, signed overflow and back-pressure.

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla_pipe_adder_if.sv | 24 ++
 rtl/cla_slice.sv | 42 ++++
 rtl/cla_pipe_adder.sv | 99 +++++++++
 tb/tb_cla_pipe_adder.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int slice_width(input int width, input int pipe);
    return width / pipe;
  endfunction

  // Guarded so a PIPE of 0 never reaches the modulo.
  function automatic bit cfg_ok(input int width, input int pipe);
    if (pipe < 1 || pipe > width) return 1'b0;
    return (width % pipe) == 0;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder; slave is the adder side.
interface cla_pipe_adder_if #(parameter int WIDTH = 32);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_add1;
  logic [WIDTH-1:0] i_add2;
  logic             i_cin;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_cout;
  logic             o_ovf;

  modport slave (
    input  i_valid, i_add1, i_add2, i_cin, i_sub, i_ready,
    output o_ready, o_valid, o_result, o_cout, o_ovf
  );

  modport master (
    output i_valid, i_add1, i_add2, i_cin, i_sub, i_ready,
    input  o_ready, o_valid, o_result, o_cout, o_ovf
  );
endinterface

// File: rtl/cla_slice.sv
// Single-cycle carry-lookahead unit for one SW-bit slice of the adder.
module cla_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_cin,
  output logic [SW-1:0] o_sum,
  output logic          o_cout,
  output logic          o_c_msb_in
);

  logic [SW-1:0] w_g;
  logic [SW-1:0] w_p;
  logic [SW:0]   w_c;
  logic          w_term;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is the flat sum-of-products of generate/propagate terms, not a ripple chain.
  always_comb begin
    w_c    = '0;
    w_term = 1'b0;
    w_c[0] = i_cin;
    for (int i = 0; i < SW; i++) begin
      w_term = i_cin;
      for (int m = 0; m <= i; m++) w_term = w_term & w_p[m];
      w_c[i+1] = w_term;
      for (int j = 0; j <= i; j++) begin
        w_term = w_g[j];
        for (int m = j + 1; m <= i; m++) w_term = w_term & w_p[m];
        w_c[i+1] = w_c[i+1] | w_term;
      end
    end
  end

  assign o_sum      = w_p ^ w_c[SW-1:0];
  assign o_cout     = w_c[SW];
  assign o_c_msb_in = w_c[SW-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: one slice per stage, carry registered between slices,
// whole pipe advances together and freezes when the output is stalled.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PIPE  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  cla_pipe_adder_if.slave io_bus
);

  localparam int SW = slice_width(WIDTH, PIPE);

  if (!cfg_ok(WIDTH, PIPE)) begin : g_cfg_err
    $error("cla_pipe_adder: PIPE must be >= 1 and divide WIDTH");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_a_in [PIPE];
  logic [WIDTH-1:0] w_b_in [PIPE];
  logic [WIDTH-1:0] w_s_in [PIPE];
  logic             w_c_in [PIPE];
  logic             w_v_in [PIPE];
  logic [SW-1:0]    w_sum  [PIPE];
  logic             w_co   [PIPE];
  logic             w_cm   [PIPE];

  logic [WIDTH-1:0] r_a [PIPE];
  logic [WIDTH-1:0] r_b [PIPE];
  logic [WIDTH-1:0] r_s [PIPE];
  logic             r_c [PIPE];
  logic             r_v [PIPE];
  logic             r_ovf;

  assign w_adv = ~r_v[PIPE-1] | io_bus.i_ready;

  // Operands shift right one slice per stage so the live slice is always at bit 0;
  // sums enter at the top and shift right, landing in place after the last stage.
  always_comb begin
    for (int k = 0; k < PIPE; k++) begin
      w_a_in[k] = '0;
      w_b_in[k] = '0;
      w_s_in[k] = '0;
      w_c_in[k] = 1'b0;
      w_v_in[k] = 1'b0;
    end
    w_a_in[0] = io_bus.i_add1;
    w_b_in[0] = io_bus.i_add2 ^ {WIDTH{io_bus.i_sub == MODE_SUB}};
    w_c_in[0] = (io_bus.i_sub == MODE_SUB) ? 1'b1 : io_bus.i_cin;
    w_v_in[0] = io_bus.i_valid;
    for (int k = 1; k < PIPE; k++) begin
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_s_in[k] = r_s[k-1];
      w_c_in[k] = r_c[k-1];
      w_v_in[k] = r_v[k-1];
    end
  end

  for (genvar k = 0; k < PIPE; k++) begin : g_slice
    cla_slice #(.SW(SW)) u_slice (
      .i_a        (w_a_in[k][SW-1:0]),
      .i_b        (w_b_in[k][SW-1:0]),
      .i_cin      (w_c_in[k]),
      .o_sum      (w_sum[k]),
      .o_cout     (w_co[k]),
      .o_c_msb_in (w_cm[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < PIPE; k++) begin
        r_v[k] <= 1'b0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < PIPE; k++) begin
        r_v[k] <= w_v_in[k];
        r_a[k] <= w_a_in[k] >> SW;
        r_b[k] <= w_b_in[k] >> SW;
        r_s[k] <= (w_s_in[k] >> SW) | (WIDTH'(w_sum[k]) << (WIDTH - SW));
        r_c[k] <= w_co[k];
      end
      r_ovf <= w_co[PIPE-1] ^ w_cm[PIPE-1];
    end
  end

  assign io_bus.o_ready  = w_adv;
  assign io_bus.o_valid  = r_v[PIPE-1];
  assign io_bus.o_result = r_s[PIPE-1];
  assign io_bus.o_cout   = r_c[PIPE-1];
  assign io_bus.o_ovf    = r_ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed corner cases, streaming, stall,
// reset flush and a random soak scored against an arithmetic reference model.
module tb_cla_pipe_adder;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  cla_pipe_adder_if #(.WIDTH(32)) bus   ();
  cla_pipe_adder_if #(.WIDTH(32)) bus1  ();
  cla_pipe_adder_if #(.WIDTH(32)) bus32 ();

  cla_pipe_adder #(.WIDTH(32), .PIPE(4))  u_dut   (.i_clk(clk), .i_rst(rst), .io_bus(bus));
  cla_pipe_adder #(.WIDTH(32), .PIPE(1))  u_dut1  (.i_clk(clk), .i_rst(rst), .io_bus(bus1));
  cla_pipe_adder #(.WIDTH(32), .PIPE(32)) u_dut32 (.i_clk(clk), .i_rst(rst), .io_bus(bus32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {ovf, cout, result} from plain signed/unsigned arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    longint sa, sb, sr, ci;
    logic [32:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = cin ? 64'sd1 : 64'sd0;
    if (sub) begin
      sr = sa - sb;
      u  = {1'b0, a} - {1'b0, b};
      return {(sr > SMAX || sr < SMIN), (a >= b), u[31:0]};
    end
    sr = sa + sb + ci;
    u  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    return {(sr > SMAX || sr < SMIN), u[32], u[31:0]};
  endfunction

  logic [33:0] sb_q [$];
  logic [33:0] sb_exp;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (bus.o_valid && bus.i_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_extra_output", bus.o_valid, 1'b0);
        end else begin
          sb_exp = sb_q.pop_front();
          check("sb_result", bus.o_result, sb_exp[31:0]);
          check("sb_cout",   bus.o_cout,   sb_exp[32]);
          check("sb_ovf",    bus.o_ovf,    sb_exp[33]);
        end
      end
      if (bus.i_valid && bus.o_ready)
        sb_q.push_back(model(bus.i_add1, bus.i_add2, bus.i_cin, bus.i_sub));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    bus.i_add1 = $urandom;
    case ($urandom_range(0, 4))
      0:       bus.i_add2 = ~bus.i_add1;
      1:       bus.i_add2 = bus.i_add1;
      default: bus.i_add2 = $urandom;
    endcase
    bus.i_cin   = 1'($urandom_range(0, 1));
    bus.i_sub   = 1'($urandom_range(0, 1));
    bus.i_valid = 1'b1;
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub,
                          input logic [31:0] er, input logic ec, input logic eo);
    bus.i_add1  = a;
    bus.i_add2  = b;
    bus.i_cin   = cin;
    bus.i_sub   = sub;
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      check({tag, "_lat_valid"}, bus.o_valid, (n == 4));
      if (n < 4) step();
    end
    check({tag, "_result"}, bus.o_result, er);
    check({tag, "_cout"},   bus.o_cout,   ec);
    check({tag, "_ovf"},    bus.o_ovf,    eo);
    step();
  endtask

  logic [31:0] held_res;
  logic        held_c;
  logic        held_o;
  logic        pending;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.i_valid = 1'b0; bus.i_add1 = '0; bus.i_add2 = '0;
    bus.i_cin = 1'b0; bus.i_sub = 1'b0; bus.i_ready = 1'b1;
    bus1.i_valid = 1'b0; bus1.i_add1 = '0; bus1.i_add2 = '0;
    bus1.i_cin = 1'b0; bus1.i_sub = 1'b0; bus1.i_ready = 1'b1;
    bus32.i_valid = 1'b0; bus32.i_add1 = '0; bus32.i_add2 = '0;
    bus32.i_cin = 1'b0; bus32.i_sub = 1'b0; bus32.i_ready = 1'b1;
    step();
    step();
    check("rst_valid",   bus.o_valid,   1'b0);
    check("rst_result",  bus.o_result,  32'h0);
    check("rst_cout",    bus.o_cout,    1'b0);
    check("rst_ovf",     bus.o_ovf,     1'b0);
    check("rst_valid_p1",  bus1.o_valid,  1'b0);
    check("rst_valid_p32", bus32.o_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_ready", bus.o_ready, 1'b1);

    directed("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    directed("add_cin", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

    // Back-to-back stream: valid for exactly 8 cycles starting 4 edges after the first accept.
    for (int e = 0; e < 13; e++) begin
      if (e < 8) drive_rand();
      else       bus.i_valid = 1'b0;
      step();
      check("stream_valid", bus.o_valid, (e + 1 >= 4 && e + 1 <= 11));
    end

    // Stall with the output valid: pipe and outputs must freeze for 3 cycles.
    for (int e = 0; e < 10; e++) begin
      if (e < 8) drive_rand();
      else       bus.i_valid = 1'b0;
      if (e == 5) begin
        bus.i_ready = 1'b0;
        #1;
        check("stall_ready_now", bus.o_ready, 1'b0);
        check("stall_valid_now", bus.o_valid, 1'b1);
        held_res = bus.o_result;
        held_c   = bus.o_cout;
        held_o   = bus.o_ovf;
        for (int s = 0; s < 3; s++) begin
          step();
          check("stall_ready",  bus.o_ready,  1'b0);
          check("stall_valid",  bus.o_valid,  1'b1);
          check("stall_result", bus.o_result, held_res);
          check("stall_cout",   bus.o_cout,   held_c);
          check("stall_ovf",    bus.o_ovf,    held_o);
        end
        bus.i_ready = 1'b1;
      end
      step();
    end
    bus.i_valid = 1'b0;
    repeat (6) step();
    check("stall_drained", sb_q.size(), 0);

    // Reset with three operations in flight.
    for (int e = 0; e < 3; e++) begin
      drive_rand();
      step();
    end
    bus.i_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("flush_valid",  bus.o_valid,  1'b0);
    check("flush_result", bus.o_result, 32'h0);
    check("flush_ready",  bus.o_ready,  1'b1);
    for (int e = 0; e < 6; e++) begin
      step();
      check("flush_no_stale", bus.o_valid, 1'b0);
    end

    // Latency 1 and 32 for the degenerate and fully sliced configurations.
    bus1.i_add1 = 32'h7FFF_FFFF;  bus1.i_add2 = 32'h0;  bus1.i_cin = 1'b1;  bus1.i_sub = 1'b0;
    bus32.i_add1 = 32'h7FFF_FFFF; bus32.i_add2 = 32'h0; bus32.i_cin = 1'b1; bus32.i_sub = 1'b0;
    bus1.i_valid = 1'b1;
    bus32.i_valid = 1'b1;
    step();
    bus1.i_valid = 1'b0;
    bus32.i_valid = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      check("p1_valid",  bus1.o_valid,  (n == 1));
      check("p32_valid", bus32.o_valid, (n == 32));
      if (n == 1) begin
        check("p1_result", bus1.o_result, 32'h8000_0000);
        check("p1_ovf",    bus1.o_ovf,    1'b1);
        check("p1_cout",   bus1.o_cout,   1'b0);
      end
      if (n == 32) begin
        check("p32_result", bus32.o_result, 32'h8000_0000);
        check("p32_ovf",    bus32.o_ovf,    1'b1);
        check("p32_cout",   bus32.o_cout,   1'b0);
      end
      if (n < 32) step();
    end
    step();

    // Random soak with random valid and back-pressure; the scoreboard checks every result.
    pending = 1'b0;
    for (int c = 0; c < 300; c++) begin
      bus.i_ready = ($urandom_range(0, 3) != 0);
      if (!pending) begin
        if ($urandom_range(0, 2) != 0) begin
          drive_rand();
          pending = 1'b1;
        end else begin
          bus.i_valid = 1'b0;
        end
      end
      #1;
      if (bus.i_valid && bus.o_ready) pending = 1'b0;
      step();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (8) step();
    check("soak_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
